ws2812_frame_ctrl: RTL and testbench

WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

---
 rtl/ws2812_frame_ctrl_if.sv | 21 ++
 rtl/ws2812_frame_ctrl.sv | 118 +++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_ctrl_if.sv
// Signal bundle between the WS2812 frame controller (master) and the host /
// pixel-data side (slave).
interface ws2812_frame_ctrl_if;
  logic       frame_start;
  logic       bit_in;
  logic [6:0] cnt_pixel;
  logic [4:0] cnt_bit;
  logic       dout;
  logic       busy;
  logic       frame_done;

  modport master (
    input  frame_start, bit_in,
    output cnt_pixel, cnt_bit, dout, busy, frame_done
  );

  modport slave (
    output frame_start, bit_in,
    input  cnt_pixel, cnt_bit, dout, busy, frame_done
  );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame serialiser: IDLE -> SEND (PIXELS x 24 bits) -> LATCH gap.
// Define WS2812_AUTO_REFRESH_EN to restart SEND after every latch gap.
module ws2812_frame_ctrl #(
  parameter int T_BIT  = 60,
  parameter int T0H    = 15,
  parameter int T1H    = 45,
  parameter int T_RST  = 14000,
  parameter int PIXELS = 64
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  ws2812_frame_ctrl_if.master  bus
);

  localparam int CYC_MAX = (T_BIT > T_RST) ? T_BIT : T_RST;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [CYC_W-1:0] BIT_LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(T_RST - 1);
  localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [6:0]       PIX_LAST = 7'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cnt_cyc_q, cnt_cyc_d;
  logic [6:0]       cnt_pixel_q, cnt_pixel_d;
  logic [4:0]       cnt_bit_q, cnt_bit_d;
  logic             dout_q, dout_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_cyc_q   <= '0;
      cnt_pixel_q <= '0;
      cnt_bit_q   <= '0;
      dout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_cyc_q   <= cnt_cyc_d;
      cnt_pixel_q <= cnt_pixel_d;
      cnt_bit_q   <= cnt_bit_d;
      dout_q      <= dout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_cyc_d   = cnt_cyc_q;
    cnt_pixel_d = cnt_pixel_q;
    cnt_bit_d   = cnt_bit_q;
    dout_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d     = SEND;
          cnt_cyc_d   = '0;
          cnt_pixel_d = '0;
          cnt_bit_d   = '0;
        end
      end

      SEND: begin
        // pixel/bit indices stay put for the whole bit, so bit_in is stable here
        dout_d = (cnt_cyc_q < (bus.bit_in ? T1H_C : T0H_C));
        if (cnt_cyc_q == BIT_LAST) begin
          cnt_cyc_d = '0;
          if (cnt_bit_q == 5'd23) begin
            cnt_bit_d = '0;
            if (cnt_pixel_q == PIX_LAST) begin
              cnt_pixel_d = '0;
              state_d     = LATCH;
            end else begin
              cnt_pixel_d = cnt_pixel_q + 7'd1;
            end
          end else begin
            cnt_bit_d = cnt_bit_q + 5'd1;
          end
        end else begin
          cnt_cyc_d = cnt_cyc_q + CYC_ONE;
        end
      end

      LATCH: begin
        if (cnt_cyc_q == RST_LAST) begin
          cnt_cyc_d = '0;
`ifdef WS2812_AUTO_REFRESH_EN
          state_d   = SEND;
`else
          state_d   = IDLE;
`endif
        end else begin
          cnt_cyc_d = cnt_cyc_q + CYC_ONE;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_cyc_d = '0;
      end
    endcase
  end

  // frame_done marks the last latch cycle itself, while busy is still high
  assign bus.frame_done = (state_q == LATCH) && (cnt_cyc_q == RST_LAST);
  assign bus.busy       = (state_q != IDLE);
  assign bus.dout       = dout_q;
  assign bus.cnt_pixel  = cnt_pixel_q;
  assign bus.cnt_bit    = cnt_bit_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: random/directed pixel data compared against a
// frame-timeline reference model derived from the WS2812 timing rules.
module tb_ws2812_frame_ctrl;

  localparam int T_BIT     = 6;
  localparam int T0H       = 2;
  localparam int T1H       = 4;
  localparam int T_RST     = 10;
  localparam int PIXELS    = 2;
  localparam int SEND_LEN  = PIXELS * 24 * T_BIT;
  localparam int FRAME_LEN = SEND_LEN + T_RST;

  logic clk = 1'b0;
  logic rst_n;
  logic tb_bit;
  logic [23:0] pix [PIXELS];

  int checks = 0;
  int errors = 0;

  ws2812_frame_ctrl_if bus();

  ws2812_frame_ctrl #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H),
    .T_RST (T_RST),
    .PIXELS(PIXELS)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Pixel-data source: returns the addressed colour bit, MSB of each word first.
  always_comb begin
    int p;
    int b;
    tb_bit = 1'b0;
    p = int'(bus.cnt_pixel);
    b = int'(bus.cnt_bit);
    if (p < PIXELS && b < 24) tb_bit = pix[p][23 - b];
  end
  assign bus.bit_in = tb_bit;

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs at cycle t of a frame (t=0 is the first SEND cycle).
  task automatic model(input int t, output logic e_dout, output logic e_busy,
                       output logic e_done, output logic [6:0] e_pix, output logic [4:0] e_bit);
    int tp;
    logic b;
    e_busy = 1'b1;
    e_done = (t == FRAME_LEN - 1);
    e_pix  = '0;
    e_bit  = '0;
    if (t < SEND_LEN) begin
      e_pix = 7'(t / (24 * T_BIT));
      e_bit = 5'((t / T_BIT) % 24);
    end
    e_dout = 1'b0;
    if (t > 0) begin
      tp = t - 1;
      if (tp < SEND_LEN) begin
        b = pix[tp / (24 * T_BIT)][23 - ((tp / T_BIT) % 24)];
        e_dout = ((tp % T_BIT) < (b ? T1H : T0H));
      end
    end
  endtask

  task automatic check_frame_cycle(input int t);
    logic e_dout, e_busy, e_done;
    logic [6:0] e_pix;
    logic [4:0] e_bit;
    model(t, e_dout, e_busy, e_done, e_pix, e_bit);
    check("dout",       t, 32'(bus.dout),       32'(e_dout));
    check("busy",       t, 32'(bus.busy),       32'(e_busy));
    check("frame_done", t, 32'(bus.frame_done), 32'(e_done));
    check("cnt_pixel",  t, 32'(bus.cnt_pixel),  32'(e_pix));
    check("cnt_bit",    t, 32'(bus.cnt_bit),    32'(e_bit));
  endtask

  task automatic check_idle(input string tag, input int t);
    check({tag, "_dout"},  t, 32'(bus.dout),       32'd0);
    check({tag, "_busy"},  t, 32'(bus.busy),       32'd0);
    check({tag, "_done"},  t, 32'(bus.frame_done), 32'd0);
    check({tag, "_pixel"}, t, 32'(bus.cnt_pixel),  32'd0);
    check({tag, "_bit"},   t, 32'(bus.cnt_bit),    32'd0);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle(tag, i);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < PIXELS; i++) pix[i] = 24'($urandom);
  endtask

  task automatic fill_const(input logic [23:0] v);
    for (int i = 0; i < PIXELS; i++) pix[i] = v;
  endtask

  // One frame from a single start pulse; optional re-pulses while busy, or a
  // reset dropped in at cycle abort_at.
  task automatic run_frame(input bit repulse, input int abort_at);
    @(negedge clk);
    bus.frame_start = 1'b1;
    for (int t = 0; t < FRAME_LEN; t++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      check_frame_cycle(t);
      if (repulse && (t == 50 || t == FRAME_LEN - 1)) bus.frame_start = 1'b1;
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle("async_rst", t);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
    check_idle("after_frame", FRAME_LEN);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    fill_const(24'hFFFFFF);
    #1;
    check_idle("in_reset", 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles("no_start", 100);

`ifdef WS2812_AUTO_REFRESH_EN
    fill_random();
    @(negedge clk);
    bus.frame_start = 1'b1;
    for (int t = 0; t < 3 * FRAME_LEN; t++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      check_frame_cycle(t % FRAME_LEN);
    end
    rst_n = 1'b0;
    #1;
    check_idle("auto_rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles("auto_after_rst", 10);
`else
    fill_const(24'hFFFFFF);
    run_frame(1'b0, -1);
    idle_cycles("ones_idle", 5);

    fill_const(24'h800000);
    run_frame(1'b0, -1);
    idle_cycles("first_bit_idle", 5);

    fill_random();
    run_frame(1'b1, -1);
    idle_cycles("repulse_idle", 20);

    fill_random();
    run_frame(1'b0, 70);
    idle_cycles("post_abort", 20);
    fill_random();
    run_frame(1'b0, -1);

    fill_random();
    run_frame(1'b0, -1);
    idle_cycles("final_idle", 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
